// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU opcodes, default widths and fetch sequencer state enum
package cpu_pkg;
  localparam int PC_W = 10;
  localparam int INSTR_W = 16;
  localparam logic [5:0] OP_J = 6'b110000;
  localparam logic [5:0] OP_JZ = 6'b110001;
  localparam logic [5:0] OP_JNZ = 6'b110010;
  localparam logic [3:0] JMP_PREFIX = 4'b1100;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} fetch_state_t;
  function automatic logic is_jump(input logic [5:0] op);
    return op[5:2] == JMP_PREFIX;
  endfunction
endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: combinational next-PC select, pc+1 (wrapping) when s_inc else jump target
module pc_next
  import cpu_pkg::*;
#(
  parameter int W = PC_W
) (
  input  logic [W-1:0] pc,
  input  logic         s_inc,
  input  logic [W-1:0] target,
  output logic [W-1:0] next_pc
);
  assign next_pc = s_inc ? pc + 1'b1 : target;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer fetching over imem req/ack, holding each instr for EXEC; FETCH_RETIRE_CNT_EN adds retired counter
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               s_inc,
  input  logic               hold,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         Opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc
`ifdef FETCH_RETIRE_CNT_EN
  , output logic [31:0]      retired
`endif
);
  fetch_state_t state;
  logic [PC_W-1:0] npc;
  pc_next #(.W(PC_W)) u_pc_next (
    .pc(pc),
    .s_inc(s_inc),
    .target(instr[PC_W-1:0]),
    .next_pc(npc)
  );
  assign imem_addr = pc;
  assign Opcode = instr[INSTR_W-1 -: 6];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      instr <= '0;
      instr_valid <= 1'b0;
      imem_req <= 1'b0;
    end else
      case (state)
        IDLE: begin
          state <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH:
          if (imem_ack) begin
            instr <= imem_data;
            imem_req <= 1'b0;
            instr_valid <= 1'b1;
            state <= EXEC;
          end
        EXEC:
          if (!hold) begin
            pc <= npc;
            instr_valid <= 1'b0;
            imem_req <= 1'b1;
            state <= FETCH;
          end
        default: state <= IDLE;
      endcase
`ifdef FETCH_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) retired <= '0;
    else if (state == EXEC && !hold) retired <= retired + 1'b1;
`endif
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter sequencer that supplies opcodes to the processor's control unit (`uc`). It consumes the control unit's `s_inc` output to pick the next PC. Each instruction is fetched from instruction memory over a req/ack handshake, then held stable for one execute cycle. The block sits between instruction memory and `uc`/datapath, so the processor can run from a real memory with wait states.

## Interface
- `PC_W`, 10: program counter and jump-target width.
- `INSTR_W`, 16: instruction word width; Opcode is `instr[INSTR_W-1 -: 6]`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request, held until ack.
- `imem_addr` out PC_W: fetch address; equals `pc` while `imem_req` is high.
- `imem_ack` in 1: memory returns `imem_data` this cycle.
- `imem_data` in INSTR_W: instruction word, sampled when `imem_req && imem_ack`.
- `s_inc` in 1: from `uc`; 1 = PC+1, 0 = jump to target.
- `hold` in 1: stall request; freezes EXEC.
- `instr` out INSTR_W: latched instruction.
- `Opcode` out 6: `instr[INSTR_W-1:INSTR_W-6]`.
- `instr_valid` out 1: high during EXEC.
- `pc` out PC_W: address of the current instruction.

## Operation
- Three states: IDLE, FETCH and EXEC.
- IDLE: entered on reset. Leaves for FETCH on the first clock edge after reset deasserts. Any `imem_ack` seen in IDLE is ignored.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`=1: `instr` <= `imem_data`, go to EXEC.
  - Ack in the same cycle as req is legal.
  - The address is stable for the whole wait.
- EXEC: `instr_valid`=1 and `imem_req`=0.
  - If `hold`=1: stay in EXEC, and `pc`/`instr` do not change.
  - Else, at the rising edge: `pc` <= `s_inc` ? `pc`+1 : `instr[PC_W-1:0]`, then go to FETCH.
- PC arithmetic is modulo 2^PC_W. From `pc` = 2^PC_W−1 with `s_inc`=1, the next PC is 0.
- A jump to the current `pc` (a self-loop) is legal and refetches the same address.
- `s_inc` is sampled only at the EXEC-exit edge. Its value in other states has no effect.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `pc`=0, `instr`=0, `Opcode`=0, `instr_valid`=0, `imem_req`=0, `imem_addr`=0.
- Reset mid-fetch drops `imem_req` in the same cycle. A pending ack after reset is ignored.
- Throughput with zero-wait memory: 2 cycles per instruction (FETCH 1 cycle, EXEC 1 cycle). Each wait cycle adds 1.
- `instr` and `Opcode` change only on the FETCH→EXEC edge and stay stable through all of EXEC. `uc` evaluates them on the falling edge inside EXEC.
- `hold` asserted during FETCH has no effect there; it takes effect in the EXEC that follows.

## Configuration
- `FETCH_RETIRE_CNT_EN` defined: adds output port `retired` [31:0].
  - Reset value 0.
  - Increments by 1 on every EXEC→FETCH transition.
  - Wraps at 2^32.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_J`=6'b110000, `OP_JZ`=6'b110001, `OP_JNZ`=6'b110010;
  - the jump-class prefix 4'b1100;
  - default widths `PC_W`/`INSTR_W`;
  - the fetch state enum {IDLE, FETCH, EXEC}.
- One sub-module, `pc_next`: combinational next-PC select (`pc`, `s_inc`, target → next PC), reused later by any branch-prediction work.

## Test plan
- Reset: assert `reset` mid-FETCH with `pc`=5 → `imem_req`=0 and `pc`=0 immediately. A late `imem_ack` is ignored, and the first request after release is to address 0.
- Sequential, zero-wait: memory acks every request, `s_inc`=1 → addresses 0,1,2,3 are fetched on every second cycle, and `instr_valid` toggles 0,1,0,1.
- Jump: `instr`=16'hC07B (`OP_J`, target 0x07B), `s_inc`=0 → next `imem_addr`=0x07B.
- Wait states and hold:
  - ack delayed 3 cycles → `imem_addr` stays constant and `imem_req` stays high for 3 cycles;
  - `hold`=1 for 4 cycles in EXEC → `instr_valid` stays high for 5 cycles, with `pc` unchanged.
- Wrap: `pc`=10'h3FF, `s_inc`=1 → next fetch address is 0.
- With `FETCH_RETIRE_CNT_EN`: 10 completed instructions, including one held EXEC → `retired`=10.
